// File: rtl/bch_encoder_31_16.sv
// Systematic serial BCH(31,16) encoder (t=3, GF(2^5), p(x)=x^5+x^2+1).
// Message bits pass straight through, then the 15 LFSR parity bits follow.
module bch_encoder_31_16 #(
  parameter int          N   = 31,
  parameter int          K   = 16,
  parameter int          NP  = 15,
  parameter logic [14:0] GEN = 15'h0FAF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          abort,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_bit,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_bit,
  output logic          out_first,
  output logic          out_last,
  output logic [NP-1:0] parity,
  output logic          parity_valid,
  output logic [15:0]   cw_count
);

  typedef enum logic {MSG, PARITY} state_t;

  localparam logic [3:0] MSG_LAST = 4'(K - 1);
  localparam logic [3:0] PAR_LAST = 4'(N - K - 1);

  state_t          state;
  logic [3:0]      cnt;
  logic [NP-1:0]   r;
  logic [NP-1:0]   r_div;
  logic [NP-1:0]   shadow;
  logic            fb;
  logic            msg_beat;
  logic            par_beat;

  // Division step of m(x)*x^15 by g(x); x^15 term handled by the feedback.
  assign fb    = in_bit ^ r[NP-1];
  assign r_div = {r[NP-2:0], 1'b0} ^ (fb ? GEN : '0);

  assign msg_beat = !abort && (state == MSG) && in_valid && out_ready;
  assign par_beat = !abort && (state == PARITY) && out_ready;

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_bit   = 1'b0;
    out_first = 1'b0;
    out_last  = 1'b0;
    if (!abort) begin
      case (state)
        MSG: begin
          out_valid = in_valid;
          in_ready  = out_ready;
          out_bit   = in_bit;
          out_first = (cnt == '0);
        end
        PARITY: begin
          out_valid = 1'b1;
          out_bit   = r[NP-1];
          out_last  = (cnt == PAR_LAST);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= MSG;
      cnt          <= '0;
      r            <= '0;
      shadow       <= '0;
      parity       <= '0;
      parity_valid <= 1'b0;
      cw_count     <= '0;
    end else begin
      parity_valid <= 1'b0;
      if (abort) begin
        state <= MSG;
        cnt   <= '0;
        r     <= '0;
      end else if (msg_beat) begin
        r <= r_div;
        if (cnt == MSG_LAST) begin
          state  <= PARITY;
          cnt    <= '0;
          shadow <= r_div;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end else if (par_beat) begin
        // Shifting out the parity leaves r cleared for the next codeword.
        r <= {r[NP-2:0], 1'b0};
        if (cnt == PAR_LAST) begin
          state        <= MSG;
          cnt          <= '0;
          parity       <= shadow;
          parity_valid <= 1'b1;
          cw_count     <= cw_count + 16'd1;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bch_encoder_31_16.sv
// Scoreboard bench for bch_encoder_31_16: polynomial-division reference model,
// monitor collects serial codewords and checks them against the expected queue.
module tb_bch_encoder_31_16;

  typedef struct packed {
    logic [30:0] cw;
    logic [14:0] par;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n, abort, in_valid, in_bit, out_ready;
  logic        in_ready, out_valid, out_bit, out_first, out_last, parity_valid;
  logic [14:0] parity;
  logic [15:0] cw_count;

  int   n_cmp = 0, n_fail = 0;
  exp_t exp_q[$];
  bit   rnd_ready = 1'b0;

  // monitor state
  int          idx = 0, completed = 0, cur_run = 0, firsts = 0, lasts = 0, pv_cnt = 0;
  bit          pv_due = 1'b0, prev_beat = 1'b0;
  logic [30:0] cw_acc = '0, last_cw = '0;
  logic [14:0] last_par = '0;
  int          clr_req = 0, clr_ack = 0;
  bit          clr_full = 1'b0;

  bch_encoder_31_16 dut (
    .clk(clk), .reset_n(reset_n), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit),
    .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
    .out_first(out_first), .out_last(out_last),
    .parity(parity), .parity_valid(parity_valid), .cw_count(cw_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Remainder of v(x) modulo g(x) = 0x8FAF by long division.
  function automatic logic [14:0] poly_rem(input logic [30:0] v);
    logic [30:0] t = v;
    for (int i = 30; i >= 15; i--)
      if (t[i]) t ^= 31'(32'h8FAF << (i - 15));
    return t[14:0];
  endfunction

  function automatic logic [4:0] gf_pow(input int k);
    logic [4:0] a = 5'd1;
    for (int i = 0; i < k; i++) a = {a[3:0], 1'b0} ^ (a[4] ? 5'h05 : 5'h00);
    return a;
  endfunction

  // Decoder stub: L is 0 when all six syndromes vanish, else at least one error.
  function automatic int bm_L(input logic [30:0] c);
    logic [4:0] s;
    int L = 0;
    for (int j = 1; j <= 6; j++) begin
      s = '0;
      for (int i = 0; i < 31; i++) if (c[i]) s ^= gf_pow((i * j) % 31);
      if (s != 0) L = 1;
    end
    return L;
  endfunction

  // Monitor: samples on the falling edge, between input updates and the clock.
  initial begin
    exp_t e;
    bit beat;
    forever begin
      @(negedge clk);
      if (clr_req != clr_ack) begin
        idx = 0; cw_acc = '0;
        if (clr_full) begin completed = 0; pv_due = 1'b0; end
        clr_ack = clr_req;
      end
      if (pv_due) begin
        pv_due = 1'b0;
        if (parity_valid) pv_cnt++;
        chk("parity_valid", 32'(parity_valid), 32'd1);
        chk("parity", 32'(parity), 32'(last_par));
        chk("cw_count", 32'(cw_count), 32'(16'(completed)));
      end else if (parity_valid) begin
        chk("parity_valid_spurious", 32'(parity_valid), 32'd0);
      end
      beat = out_valid && out_ready;
      if (beat) begin
        firsts += int'(out_first);
        lasts  += int'(out_last);
        chk("out_first", 32'(out_first), 32'(idx == 0));
        chk("out_last", 32'(out_last), 32'(idx == 30));
        cur_run = prev_beat ? cur_run + 1 : 1;
        cw_acc  = {cw_acc[29:0], out_bit};
        idx++;
        if (idx == 31) begin
          idx = 0; completed++; pv_due = 1'b1; last_cw = cw_acc;
          if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("codeword", 32'(cw_acc), 32'(e.cw));
            chk("cw_mod_g", 32'(poly_rem(cw_acc)), 32'd0);
            chk("bm_L", 32'(bm_L(cw_acc)), 32'd0);
            last_par = e.par;
          end
        end
      end
      prev_beat = beat;
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      out_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Send the top n bits of m (m15 first); queue the codeword once all 16 are in.
  task automatic send_msg(input logic [15:0] m, input int n, input bit rnd);
    logic [14:0] rem;
    bit acc;
    int t;
    for (int b = 15; b > 15 - n; b--) begin
      acc = 1'b0; t = 0;
      while (!acc) begin
        in_bit   = m[b];
        in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk); #1;
        if (++t > 500) begin
          chk("in_accept_timeout", 32'd1, 32'd0);
          in_valid = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0;
    if (n == 16) begin
      rem = poly_rem({m, 15'b0});
      exp_q.push_back('{cw: {m, rem}, par: rem});
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (exp_q.size() != 0 || pv_due) begin
      @(posedge clk); #1;
      if (++t > 3000) begin
        chk("idle_timeout", 32'd1, 32'd0);
        return;
      end
    end
  endtask

  task automatic do_abort();
    in_valid = 1'b1; in_bit = 1'b1; abort = 1'b1;
    clr_full = 1'b0; clr_req++;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    int f0, l0, p0;
    reset_n = 1'b0; abort = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_parity", 32'(parity), 32'd0);
    chk("rst_parity_valid", 32'(parity_valid), 32'd0);
    chk("rst_cw_count", 32'(cw_count), 32'd0);
    #10 reset_n = 1'b1;
    @(posedge clk); #1;

    // all-zero message
    p0 = pv_cnt;
    send_msg(16'h0000, 16, 1'b0);
    wait_idle();
    chk("zero_last_cw", 32'(last_cw), 32'd0);
    chk("zero_pv_pulses", 32'(pv_cnt - p0), 32'd1);
    chk("zero_cw_count", 32'(cw_count), 32'd1);

    // single message 0x0001 gives g(x)
    send_msg(16'h0001, 16, 1'b0);
    wait_idle();
    chk("m1_parity", 32'(parity), 32'h0FAF);
    chk("m1_cw", 32'(last_cw), 32'h00008FAF);

    // back-to-back pair, no bubbles
    f0 = firsts; l0 = lasts;
    send_msg(16'h0001, 16, 1'b0);
    send_msg(16'h0002, 16, 1'b0);
    wait_idle();
    chk("m2_parity", 32'(parity), 32'h1F5E);
    chk("b2b_run", 32'(cur_run), 32'd62);
    chk("b2b_firsts", 32'(firsts - f0), 32'd2);
    chk("b2b_lasts", 32'(lasts - l0), 32'd2);

    // abort at message bit 7, then at parity bit 5
    send_msg(16'h5A5A, 7, 1'b0);
    do_abort();
    send_msg(16'hC3C3, 16, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    do_abort();
    send_msg(16'h0001, 16, 1'b0);
    wait_idle();
    chk("abort_parity", 32'(parity), 32'h0FAF);
    chk("abort_cw_count", 32'(cw_count), 32'd5);

    // asynchronous reset mid-parity
    send_msg(16'hBEEF, 16, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0; clr_full = 1'b1; clr_req++;
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'(out_ready));
    chk("arst_parity", 32'(parity), 32'd0);
    chk("arst_parity_valid", 32'(parity_valid), 32'd0);
    chk("arst_cw_count", 32'(cw_count), 32'd0);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    send_msg(16'h1234, 16, 1'b0);
    wait_idle();
    chk("post_rst_cw_count", 32'(cw_count), 32'd1);

    // randomized traffic with random backpressure and input gaps
    rnd_ready = 1'b1;
    for (int i = 0; i < 200; i++) send_msg(16'($urandom()), 16, 1'b1);
    wait_idle();
    rnd_ready = 1'b0;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
